mux_rr_nto1: RTL and testbench

- Parametrised N-to-1 data multiplexer with per-channel input FIFOs, round-robin or fixed-select arbitration, and a registered valid/ready output stage.
- Successor to the fixed 2-to-1 8-bit valid-bit muxes in the lane-combining datapath.
- Generalises channel count, data width and buffering depth.
- Adds backpressure and a selectable arbitration mode in a single clock domain.

---
 rtl/mux_rr_nto1.sv | 145 ++++++++++++++
 tb/tb_mux_rr_nto1.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_nto1
//  Purpose  : N-to-1 data multiplexer with per-channel input FIFOs,
//             round-robin or fixed-select arbitration and a registered
//             valid/ready output stage.
//  Revision : 1.0  initial release
// ============================================================================
module mux_rr_nto1 #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic                       rr_en,
    input  logic [SEL_W-1:0]           sel,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [SEL_W-1:0]           grant_ch,
    output logic [NUM_CH-1:0]          fifo_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_empty;
    logic [DATA_W-1:0] w_head [NUM_CH];

    logic              w_load;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_grant_idx;
    int                w_scan_idx;

    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic [SEL_W-1:0]  r_grant_ch;
    logic [SEL_W-1:0]  r_last_grant;

    // The output register can take a new word when it is empty or being drained.
    assign w_load = !r_valid_out || ready_out;

    // ------------------------------------------------------------------
    // Per-channel FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wr_ptr;
        logic [PTR_W-1:0]  r_rd_ptr;
        logic [CNT_W-1:0]  r_count;
        logic              w_push;
        logic              w_pop;

        // Readiness depends only on occupancy, so a full FIFO refuses a push
        // even in the cycle it is being popped.
        assign w_ready[gi] = (r_count != CNT_W'(DEPTH));
        assign w_empty[gi] = (r_count == '0);
        assign w_head[gi]  = r_mem[r_rd_ptr];
        assign w_push      = in_valid[gi] && w_ready[gi];
        assign w_pop       = w_load && w_grant_vld && (w_grant_idx == SEL_W'(gi));

        // Storage array: contents need no reset, occupancy is tracked by the count.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[gi*DATA_W +: DATA_W];
            end
        end

        // Pointers wrap naturally since DEPTH is a power of two.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign in_ready   = w_ready;
    assign fifo_empty = w_empty;

    // Arbitration: rotating scan after the last served channel, or a fixed pick.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = 0;
        if (rr_en) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                w_scan_idx = (int'(r_last_grant) + k) % NUM_CH;
                if (!w_grant_vld && !w_empty[SEL_W'(w_scan_idx)]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SEL_W'(w_scan_idx);
                end
            end
        end else if (int'(sel) < NUM_CH) begin
            if (!w_empty[sel]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = sel;
            end
        end
    end

    // Output stage: load the granted head, go idle, or hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_grant_ch   <= '0;
            r_last_grant <= SEL_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_data_out   <= w_head[w_grant_idx];
                r_valid_out  <= 1'b1;
                r_grant_ch   <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end else begin
                r_valid_out  <= 1'b0;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign grant_ch  = r_grant_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_nto1
//  Purpose  : Self-checking bench for mux_rr_nto1 against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_nto1;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int SEL_W  = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH*DATA_W-1:0]  in_data;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_ready;
    logic                      rr_en;
    logic [SEL_W-1:0]          sel;
    logic [DATA_W-1:0]         data_out;
    logic                      valid_out;
    logic                      ready_out;
    logic [SEL_W-1:0]          grant_ch;
    logic [NUM_CH-1:0]         fifo_empty;

    always #5 clk = ~clk;

    mux_rr_nto1 #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rr_en      (rr_en),
        .sel        (sel),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .grant_ch   (grant_ch),
        .fifo_empty (fifo_empty)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one queue per channel plus the visible output register.
    logic [DATA_W-1:0] mq [NUM_CH][$];
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    int                m_grant;
    int                m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_grant = 0;
        m_last  = NUM_CH - 1;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit rdy [NUM_CH];
        bit load;
        int g;
        for (int i = 0; i < NUM_CH; i++) rdy[i] = (mq[i].size() < DEPTH);
        load = !m_valid || ready_out;
        g = -1;
        if (rr_en) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
        end else if (int'(sel) < NUM_CH && mq[sel].size() > 0) begin
            g = int'(sel);
        end
        if (load) begin
            if (g >= 0) begin
                m_data  = mq[g].pop_front();
                m_valid = 1'b1;
                m_grant = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++)
            if (in_valid[i] && rdy[i]) mq[i].push_back(in_data[i*DATA_W +: DATA_W]);
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] e_empty;
        logic [NUM_CH-1:0] e_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_ready[i] = (mq[i].size() < DEPTH);
        end
        check("valid_out",  32'(valid_out),  32'(m_valid));
        check("data_out",   32'(data_out),   32'(m_data));
        check("grant_ch",   32'(grant_ch),   32'(m_grant));
        check("fifo_empty", 32'(fifo_empty), 32'(e_empty));
        check("in_ready",   32'(in_ready),   32'(e_ready));
    endtask

    // One clock: update model, let the edge happen, compare just after it.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] d);
        in_valid[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        #1;
        check_outputs();
    endtask

    logic [DATA_W-1:0] rr_exp_d [6] = '{8'h01, 8'h02, 8'h0A, 8'h0B, 8'hFF, 8'hAA};
    int                rr_exp_g [6] = '{0, 1, 2, 3, 0, 2};

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        rr_en     = 1'b1;
        sel       = '0;
        ready_out = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Round-robin fairness
        push(0, 8'h01); push(1, 8'h02); push(2, 8'h0A); push(3, 8'h0B);
        step();
        clear_inputs();
        push(0, 8'hFF); push(2, 8'hAA);
        step();
        clear_inputs();
        for (int j = 0; j < 6; j++) begin
            check("rr_valid", 32'(valid_out), 32'd1);
            check("rr_data",  32'(data_out),  32'(rr_exp_d[j]));
            check("rr_grant", 32'(grant_ch),  32'(rr_exp_g[j]));
            step();
        end
        check("rr_idle", 32'(valid_out), 32'd0);

        // Fixed select
        apply_reset();
        rr_en = 1'b0;
        sel   = 2'd2;
        push(1, 8'h05); push(2, 8'h09);
        step();
        clear_inputs();
        push(2, 8'hF1);
        step();
        clear_inputs();
        check("fix_d0", 32'(data_out), 32'h09);
        check("fix_g0", 32'(grant_ch), 32'd2);
        step();
        check("fix_d1", 32'(data_out), 32'hF1);
        step();
        check("fix_idle",  32'(valid_out),     32'd0);
        check("fix_ch1nz", 32'(fifo_empty[1]), 32'd0);
        sel = 2'd1;
        step();
        check("fix_sw_d", 32'(data_out), 32'h05);
        check("fix_sw_g", 32'(grant_ch), 32'd1);
        step();

        // Backpressure and full FIFO
        apply_reset();
        rr_en     = 1'b1;
        ready_out = 1'b0;
        for (int w = 0; w < 5; w++) begin
            clear_inputs();
            push(3, 8'h10 + 8'(w));
            step();
        end
        check("bp_full", 32'(in_ready[3]), 32'd0);
        clear_inputs();
        push(3, 8'h15);
        step();
        check("bp_hold", 32'(data_out), 32'h10);
        clear_inputs();
        ready_out = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            step();
            check("bp_drain", 32'(data_out), 32'h10 + 32'(w));
        end
        step();
        check("bp_nolost15", 32'(valid_out), 32'd0);

        // Continuous push with pointer wrap
        apply_reset();
        for (int w = 0; w < 12; w++) begin
            clear_inputs();
            push(0, 8'(w));
            step();
            if (w > 0) check("wrap_data", 32'(data_out), 32'(w - 1));
        end
        clear_inputs();
        step();
        check("wrap_last", 32'(data_out), 32'h0B);

        // Reset while stalled with queued words
        ready_out = 1'b0;
        for (int w = 0; w < 3; w++) begin
            clear_inputs();
            push(w, 8'h30 + 8'(w));
            step();
        end
        clear_inputs();
        apply_reset();
        ready_out = 1'b1;
        push(0, 8'h41); push(2, 8'h42);
        step();
        clear_inputs();
        step();
        check("post_rst_g", 32'(grant_ch), 32'd0);
        check("post_rst_d", 32'(data_out), 32'h41);

        // Randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = NUM_CH'($urandom);
            in_data   = {$urandom, $urandom} & {NUM_CH*DATA_W{1'b1}};
            ready_out = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) rr_en = ~rr_en;
            if ($urandom_range(0, 7) == 0)  sel   = SEL_W'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                clear_inputs();
                apply_reset();
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
